sram_ctrl: RTL and testbench



---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/sram_ctrl.sv | 126 ++++++++++++
 tb/tb_sram_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared state encoding, default timings and counter sizing for sram_ctrl
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_e;

  localparam int unsigned DEF_READ_WAIT = 1;
  localparam int unsigned DEF_WE_PULSE  = 1;

  // Wide enough to reach the larger of the two exit compares without wrapping.
  function automatic int unsigned wait_cnt_width(input int unsigned read_wait,
                                                 input int unsigned we_pulse);
    int unsigned m;
    m = (read_wait > we_pulse) ? read_wait : we_pulse;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-word valid/ready initiator for an asynchronous 32-bit SRAM
// Strobes and bus enable are registered from the next state so the pins never glitch.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned READ_WAIT  = DEF_READ_WAIT,
  parameter int unsigned WE_PULSE   = DEF_WE_PULSE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [31:0]           sram_data,
  output logic                  sram_ce,
  output logic                  sram_oe,
  output logic                  sram_we
);

  localparam int unsigned     CW      = wait_cnt_width(READ_WAIT, WE_PULSE);
  localparam logic [CW-1:0]   RD_LAST = CW'(READ_WAIT);
  localparam logic [CW-1:0]   WR_LAST = CW'(WE_PULSE - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    resp_q, resp_d;
  logic                    ce_q, ce_d;
  logic                    oe_q, oe_d;
  logic                    we_q, we_d;
  logic                    drive_q, drive_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = req_we ? ST_WR_SETUP : ST_RD;
        end
      end
      ST_RD: begin
        if (cnt_q == RD_LAST) begin
          rdata_d = sram_data;
          resp_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WR_SETUP: begin
        cnt_d   = '0;
        state_d = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (cnt_q == WR_LAST) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WR_HOLD: begin
        resp_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Read enable and bus drive decode from disjoint states, so they can never overlap.
    ce_d    = (state_d != ST_IDLE);
    oe_d    = (state_d == ST_RD);
    we_d    = (state_d == ST_WR_PULSE);
    drive_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) || (state_d == ST_WR_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      ce_q    <= 1'b0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      drive_q <= drive_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_q;
  assign resp_rdata = rdata_q;
  assign sram_addr  = addr_q;
  assign sram_ce    = ~ce_q;
  assign sram_oe    = ~oe_q;
  assign sram_we    = ~we_q;
  assign sram_data  = drive_q ? wdata_q : 32'bz;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - table-driven and randomized check of sram_ctrl against an SRAM model
module tb_sram_ctrl;

  localparam int AW = 20;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    bit            b2b;
    bit            scramble;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid [2];
  logic          req_we    [2];
  logic [AW-1:0] req_addr  [2];
  logic [31:0]   req_wdata [2];
  logic          req_ready [2];
  logic          resp_valid[2];
  logic [31:0]   resp_rdata[2];
  logic [AW-1:0] sram_addr [2];
  logic          ce [2];
  logic          oe [2];
  logic          we [2];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] shadow [int];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  function automatic int rw_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int wp_of(input int g);
    return (g == 0) ? 1 : 2;
  endfunction

  function automatic int exp_lat(input int g, input bit is_wr);
    return is_wr ? (wp_of(g) + 2) : (rw_of(g) + 1);
  endfunction

  function automatic vec_t mk(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                              input logic [31:0] e, input bit b, input bit s);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.exp_rdata = e; v.b2b = b; v.scramble = s;
    return v;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    wire  [31:0]   bus;
    logic [31:0]   mem [int];
    logic [31:0]   rd_val = 32'h0;
    int            we_run = 0;
    logic          ce_low_prev = 1'b0;
    logic [AW-1:0] held_addr = '0;

    sram_ctrl #(.ADDR_WIDTH(AW), .READ_WAIT(g == 0 ? 1 : 3), .WE_PULSE(g == 0 ? 1 : 2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_ready (req_ready[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .sram_addr (sram_addr[g]),
      .sram_data (bus),
      .sram_ce   (ce[g]),
      .sram_oe   (oe[g]),
      .sram_we   (we[g])
    );

    // Asynchronous SRAM: drives while ce and oe are low, stores on the rising edge of we.
    assign bus = (!ce[g] && !oe[g]) ? rd_val : 32'bz;

    always @(negedge clk)
      rd_val = mem.exists(int'(sram_addr[g])) ? mem[int'(sram_addr[g])] : 32'h0;

    always @(posedge we[g])
      if (!ce[g]) mem[int'(sram_addr[g])] = bus;

    always @(negedge clk) begin
      if (rst) begin
        we_run      = 0;
        ce_low_prev = 1'b0;
      end else begin
        if (!ce[g]) begin
          if (ce_low_prev) chk(sram_addr[g] == held_addr, "addr_stable", 64'(sram_addr[g]), 64'(held_addr));
          held_addr = sram_addr[g];
          chk(oe[g] || we[g], "oe_we_both_low", {63'd0, oe[g]}, 64'd1);
        end
        if (!we[g]) we_run++;
        else if (we_run != 0) begin
          chk(we_run == wp_of(g), "we_width", 64'(we_run), 64'(wp_of(g)));
          we_run = 0;
        end
        ce_low_prev = !ce[g];
      end
    end
  end

  task automatic issue(input int g, input vec_t v);
    req_valid[g] = 1'b1;
    req_we[g]    = v.we;
    req_addr[g]  = v.addr;
    req_wdata[g] = v.wdata;
  endtask

  task automatic complete(input int g, input vec_t v);
    int k;
    k = 0;
    while (!req_ready[g] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(req_ready[g], "accept_timeout", {63'd0, req_ready[g]}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    if (!v.scramble) req_valid[g] = 1'b0;
    k = 1;
    while (!resp_valid[g] && k < 40) begin
      if (v.scramble) begin
        req_addr[g]  = AW'($urandom);
        req_wdata[g] = $urandom;
        req_we[g]    = 1'($urandom);
      end
      @(negedge clk);
      k++;
    end
    chk((k - 1) == exp_lat(g, v.we), v.we ? "wr_latency" : "rd_latency", 64'(k - 1), 64'(exp_lat(g, v.we)));
    chk(resp_rdata[g] == v.exp_rdata, v.we ? "rdata_after_wr" : "rdata", 64'(resp_rdata[g]), 64'(v.exp_rdata));
  endtask

  task automatic run_vecs(input int g, input vec_t vs[$]);
    for (int i = 0; i < vs.size(); i++) begin
      if (i == 0 || !vs[i].b2b) begin
        @(negedge clk);
        issue(g, vs[i]);
      end
      complete(g, vs[i]);
      if (i + 1 < vs.size() && vs[i + 1].b2b) begin
        chk(req_ready[g], "b2b_ready", {63'd0, req_ready[g]}, 64'd1);
        issue(g, vs[i + 1]);
      end else begin
        req_valid[g] = 1'b0;
        @(negedge clk);
        chk(!resp_valid[g], "resp_pulse", {63'd0, resp_valid[g]}, 64'd0);
      end
    end
  endtask

  task automatic random_run(input int g, input int n);
    vec_t vs[$];
    vec_t v;
    int   key;
    for (int i = 0; i < n; i++) begin
      v.we       = 1'($urandom);
      v.addr     = 20'h80000 | AW'($urandom_range(0, 7));
      v.wdata    = $urandom;
      v.b2b      = 1'($urandom);
      v.scramble = ($urandom_range(0, 3) == 0);
      key        = (g << 20) | int'(v.addr);
      if (v.we) begin
        shadow[key] = v.wdata;
      end else begin
        last_rd[g] = shadow.exists(key) ? shadow[key] : 32'h0;
      end
      v.exp_rdata = last_rd[g];
      vs.push_back(v);
    end
    run_vecs(g, vs);
  endtask

  task automatic check_idle(input int g, input string tag);
    chk(ce[g] && oe[g] && we[g], {tag, "_strobes"}, {61'd0, ce[g], oe[g], we[g]}, 64'h7);
    chk(req_ready[g], {tag, "_ready"}, {63'd0, req_ready[g]}, 64'd1);
    chk(!resp_valid[g], {tag, "_resp_valid"}, {63'd0, resp_valid[g]}, 64'd0);
    chk(resp_rdata[g] == 32'h0, {tag, "_rdata"}, 64'(resp_rdata[g]), 64'd0);
    chk(sram_addr[g] == '0, {tag, "_addr"}, 64'(sram_addr[g]), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tab[$];
    vec_t sweep[$];
    bit   saw_resp;

    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0; req_we[g] = 1'b0; req_addr[g] = '0; req_wdata[g] = '0;
      last_rd[g] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) check_idle(g, "reset");

    tab.push_back(mk(1'b1, 20'h00010, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0));
    tab.push_back(mk(1'b0, 20'h00010, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0));
    tab.push_back(mk(1'b1, 20'h00000, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0));
    tab.push_back(mk(1'b0, 20'hFFFFF, 32'h0,        32'h0,        1'b1, 1'b0));
    tab.push_back(mk(1'b1, 20'hFFFFF, 32'hA5A55A5A, 32'h0,        1'b1, 1'b0));
    tab.push_back(mk(1'b0, 20'h00000, 32'h0,        32'h12345678, 1'b1, 1'b0));
    tab.push_back(mk(1'b0, 20'hFFFFF, 32'h0,        32'hA5A55A5A, 1'b1, 1'b0));
    tab.push_back(mk(1'b1, 20'h00123, 32'h0BADF00D, 32'hA5A55A5A, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 20'h00123, 32'h0,        32'h0BADF00D, 1'b1, 1'b0));
    run_vecs(0, tab);
    last_rd[0] = 32'h0BADF00D;
    random_run(0, 30);

    @(negedge clk);
    issue(0, mk(1'b1, 20'h00200, 32'h11111111, 32'h0, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk(!we[0], "we_low_before_reset", {63'd0, we[0]}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) check_idle(g, "mid_reset");
    @(negedge clk);
    rst = 1'b0;
    saw_resp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid[0]) saw_resp = 1'b1;
    end
    chk(!saw_resp, "aborted_no_resp", {63'd0, saw_resp}, 64'd0);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;

    sweep.push_back(mk(1'b1, 20'h00055, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0));
    sweep.push_back(mk(1'b0, 20'h00055, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0));
    sweep.push_back(mk(1'b1, 20'hFFFFF, 32'h5EED1234, 32'hCAFEF00D, 1'b1, 1'b0));
    sweep.push_back(mk(1'b0, 20'hFFFFF, 32'h0,        32'h5EED1234, 1'b1, 1'b0));
    run_vecs(1, sweep);
    last_rd[1] = 32'h5EED1234;
    random_run(1, 20);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
